// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI frames (opcode, address, data stream) into
// register-bus read/write strobes and a miner start pulse, and sequences
// the byte the SPI slave shifts out on MISO.
// Optional feature: define SPI_CTRL_FRAME_ERR_EN for the sticky frame_err flag.
module spi_cmd_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel,
  input  logic              byte_rcvd,
  input  logic [7:0]        rx_data,
  input  logic              data_needed,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  input  logic [7:0]        status_in,
  output logic              start
`ifdef SPI_CTRL_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam logic [7:0] OP_WR      = 8'h01;
  localparam logic [7:0] OP_RD      = 8'h02;
  localparam logic [7:0] OP_START   = 8'h10;
`ifdef SPI_CTRL_FRAME_ERR_EN
  localparam logic [7:0] OP_CLR_ERR = 8'h20;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_WR,
    S_ADDR_RD,
    S_DATA_WR,
    S_DATA_RD,
    S_IGNORE
  } state_t;

  state_t state, state_n;

  logic ssel_meta, ssel_sync;
  logic armed;
  logic rd_pend;      // address byte of a read seen, strobe goes out next clk
  logic byte_ok;      // byte_rcvd that the FSM is allowed to act on
  logic ld_addr;      // load address counter from rx_data
  logic rd_start;     // read address byte: schedule first read
  logic do_rd;        // read data byte: read strobe on next clk
  logic do_wr;        // write data byte: write strobe on next clk
  logic do_start;     // start opcode
  logic tx_zero;      // entering a state whose MISO filler is 0x00
  logic rd_busy;      // a read is scheduled or its capture is pending
`ifdef SPI_CTRL_FRAME_ERR_EN
  logic err_set, err_clr, err_end;
`endif

  // Two-flop ssel synchronizer. Resets to "selected" so a frame that is
  // already running when reset releases is not mistaken for a fresh one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssel_meta <= 1'b0;
      ssel_sync <= 1'b0;
    end else begin
      ssel_meta <= ssel;
      ssel_sync <= ssel_meta;
    end
  end

  // Opcode decoding re-arms only after ssel has been seen high since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            armed <= 1'b0;
    else if (ssel_sync) armed <= 1'b1;
  end

  assign rd_busy = rd_pend | reg_rd_en;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and per-byte actions; frame end overrides the next state.
  always_comb begin
    state_n  = state;
    byte_ok  = byte_rcvd && (armed || (state != S_IDLE));
    ld_addr  = 1'b0;
    rd_start = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    do_start = 1'b0;
    tx_zero  = 1'b0;
`ifdef SPI_CTRL_FRAME_ERR_EN
    err_set  = 1'b0;
    err_clr  = 1'b0;
    err_end  = 1'b0;
`endif
    if (byte_ok) begin
      unique case (state)
        S_IDLE: begin
          case (rx_data)
            OP_WR: begin
              state_n = S_ADDR_WR;
              tx_zero = 1'b1;
            end
            OP_RD: begin
              // status byte stays on MISO until the first read capture
              state_n = S_ADDR_RD;
            end
            OP_START: begin
              do_start = 1'b1;
              state_n  = S_IGNORE;
              tx_zero  = 1'b1;
            end
`ifdef SPI_CTRL_FRAME_ERR_EN
            OP_CLR_ERR: begin
              err_clr = 1'b1;
              state_n = S_IGNORE;
              tx_zero = 1'b1;
            end
`endif
            default: begin
`ifdef SPI_CTRL_FRAME_ERR_EN
              err_set = 1'b1;
`endif
              state_n = S_IGNORE;
              tx_zero = 1'b1;
            end
          endcase
        end
        S_ADDR_WR: begin
          ld_addr = 1'b1;
          state_n = S_DATA_WR;
          tx_zero = 1'b1;
        end
        S_DATA_WR: do_wr = 1'b1;
        S_ADDR_RD: begin
          ld_addr  = 1'b1;
          rd_start = 1'b1;
          state_n  = S_DATA_RD;
        end
        S_DATA_RD: do_rd = 1'b1;
        S_IGNORE:  ;
        default:   state_n = S_IDLE;
      endcase
    end
    if (ssel_sync) begin
`ifdef SPI_CTRL_FRAME_ERR_EN
      // frame closed before its address byte arrived
      err_end = (state_n == S_ADDR_WR) || (state_n == S_ADDR_RD);
`endif
      // let an outstanding read land in tx_data before dropping to IDLE
      if (!(rd_busy || rd_start || do_rd)) state_n = S_IDLE;
    end
  end

  // Bus strobes, write data and the read pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_en <= 1'b0;
      reg_wdata <= 8'h00;
      reg_rd_en <= 1'b0;
      rd_pend   <= 1'b0;
      start     <= 1'b0;
    end else begin
      reg_wr_en <= do_wr;
      reg_rd_en <= rd_pend | do_rd;
      rd_pend   <= rd_start;
      start     <= do_start;
      if (do_wr) reg_wdata <= rx_data;
    end
  end

  // Address counter: increments after each write strobe / read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         reg_addr <= '0;
    else if (ld_addr)                reg_addr <= ADDR_W'(rx_data);
    else if (reg_wr_en || reg_rd_en) reg_addr <= reg_addr + ADDR_W'(1);
  end

  // MISO byte: read capture wins, then 0x00 filler, then live status in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tx_data <= 8'h00;
    else if (reg_rd_en)       tx_data <= reg_rd_data;
    else if (tx_zero)         tx_data <= 8'h00;
    else if (state == S_IDLE) tx_data <= status_in;
  end

`ifdef SPI_CTRL_FRAME_ERR_EN
  // Sticky error; the clear opcode wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     frame_err <= 1'b0;
    else if (err_clr)            frame_err <= 1'b0;
    else if (err_set || err_end) frame_err <= 1'b1;
  end
`endif

  // The slave must never see tx_data move while it is loading it.
  a_tx_stable: assert property (@(posedge clk) disable iff (rst)
    (data_needed && $past(data_needed)) |-> (tx_data == $past(tx_data)));

  // Strobes are single-cycle: bytes are always several clocks apart.
  a_wr_pulse: assert property (@(posedge clk) disable iff (rst)
    reg_wr_en |=> !reg_wr_en);
  a_start_pulse: assert property (@(posedge clk) disable iff (rst)
    start |=> !start);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: drives byte-level SPI traffic directly, predicts
// strobes and MISO bytes with a per-byte frame model, and checks every cycle.
module tb_spi_cmd_ctrl;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ssel, byte_rcvd, data_needed;
  logic [7:0]        rx_data, tx_data, reg_wdata, reg_rd_data, status_in;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en, reg_rd_en, start;
`ifdef SPI_CTRL_FRAME_ERR_EN
  logic              frame_err;
`endif

  spi_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ssel(ssel), .byte_rcvd(byte_rcvd), .rx_data(rx_data),
    .data_needed(data_needed), .tx_data(tx_data), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .status_in(status_in), .start(start)
`ifdef SPI_CTRL_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [7:0] init_val(input int a);
    if (a == 16) return 8'h3C;
    if (a == 17) return 8'h5A;
    return 8'((a * 37 + 11) & 255);
  endfunction

  // register space seen by the DUT: combinational read, write on strobe
  logic [7:0] mem [256];
  assign reg_rd_data = mem[reg_addr];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (reg_wr_en) mem[reg_addr] <= reg_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %0h, expected no event", name, act);
  endtask

  // ---------------- frame model ----------------
  localparam int M_IDLE = 0, M_WADDR = 1, M_RADDR = 2, M_WR = 3, M_RD = 4, M_SKIP = 5;
  int         m_mode;
  bit         m_dead;        // frame interrupted by reset: discard everything
  bit         m_err;
  logic [7:0] m_addr, m_tx;
  logic [7:0] m_mem [256];

  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  exp_miso [$];
  int          exp_start = 0;

  task automatic model_reset(input bit mid_frame);
    m_mode = M_IDLE;
    m_dead = mid_frame;
    m_err  = 1'b0;
    m_addr = 8'h00;
    m_tx   = status_in;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
  endtask

  task automatic model_read();
    exp_rd.push_back(m_addr);
    m_tx   = m_mem[m_addr];
    m_addr = m_addr + 8'd1;
  endtask

  // MISO for a byte is whatever the model holds before the byte arrives
  task automatic model_byte(input logic [7:0] b);
    exp_miso.push_back(m_tx);
    if (!m_dead) begin
      case (m_mode)
        M_IDLE: begin
          if (b == 8'h01)      begin m_mode = M_WADDR; m_tx = 8'h00; end
          else if (b == 8'h02) m_mode = M_RADDR;
          else begin
            m_mode = M_SKIP;
            m_tx   = 8'h00;
            if (b == 8'h10) exp_start++;
`ifdef SPI_CTRL_FRAME_ERR_EN
            else if (b == 8'h20) m_err = 1'b0;
`endif
            else m_err = 1'b1;
          end
        end
        M_WADDR: begin m_addr = b; m_mode = M_WR; end
        M_WR: begin
          exp_wr.push_back({m_addr, b});
          m_mem[m_addr] = b;
          m_addr = m_addr + 8'd1;
        end
        M_RADDR: begin m_addr = b; model_read(); m_mode = M_RD; end
        M_RD: model_read();
        default: ;
      endcase
    end
  endtask

  task automatic model_frame_end();
    if (!m_dead && (m_mode == M_WADDR || m_mode == M_RADDR)) m_err = 1'b1;
    m_mode = M_IDLE;
    m_dead = 1'b0;
    m_tx   = status_in;
  endtask

  // ---------------- compare process ----------------
  logic [7:0] got_miso [$];
  int         n_start_seen = 0;
  int         n_wr_seen = 0;
  bit         dn_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        n_wr_seen++;
        if (exp_wr.size() == 0) flag("wr_unexpected", {reg_addr, reg_wdata});
        else check("wr_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
      end
      if (reg_rd_en) begin
        if (exp_rd.size() == 0) flag("rd_unexpected", reg_addr);
        else check("rd_addr", reg_addr, exp_rd.pop_front());
      end
      if (start) begin
        n_start_seen++;
        if (exp_start == 0) flag("start_unexpected", 1);
        else exp_start--;
      end
      if (data_needed) begin
        if (!dn_prev) got_miso.push_back(tx_data);
        if (exp_miso.size() == 0) flag("miso_unexpected", tx_data);
        else check("miso", tx_data, exp_miso[0]);
      end
    end
    dn_prev = data_needed;
  end

  // ---------------- stimulus ----------------
  task automatic frame_begin();
    #1 ssel = 1'b0;
    m_tx = status_in;
    repeat (4) @(posedge clk);
  endtask

  // one byte: data_needed window, shift time, byte_rcvd, gap
  task automatic send_byte(input logic [7:0] b, input bit early_end);
    model_byte(b);
    @(posedge clk); #1 data_needed = 1'b1;
    repeat (2) @(posedge clk); #1 data_needed = 1'b0;
    void'(exp_miso.pop_front());
    repeat (4) @(posedge clk);
    // raising ssel here makes its synchronized edge coincide with byte_rcvd
    #1 if (early_end) ssel = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_data = b; byte_rcvd = 1'b1;
    @(posedge clk); #1 byte_rcvd = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame_end();
    #1 ssel = 1'b1;
    model_frame_end();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("idle_tx_status", tx_data, status_in);
`ifdef SPI_CTRL_FRAME_ERR_EN
    check("frame_err", frame_err, m_err);
`endif
    @(posedge clk);
  endtask

  task automatic run_frame(input int n, input bit early, input logic [7:0] b0,
                           input logic [7:0] b1 = 8'h00, input logic [7:0] b2 = 8'h00,
                           input logic [7:0] b3 = 8'h00);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    frame_begin();
    for (int i = 0; i < n; i++) send_byte(b[i], early && (i == n - 1));
    frame_end();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, w0;
    ssel = 1'b1; byte_rcvd = 1'b0; rx_data = 8'h00; data_needed = 1'b0;
    status_in = 8'hA5;
    model_reset(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, start}, 32'h0);
`ifdef SPI_CTRL_FRAME_ERR_EN
    check("rst_frame_err", frame_err, 1'b0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("idle_status", tx_data, 8'hA5);
    @(posedge clk);

    // write two bytes from 0x05
    run_frame(4, 1'b0, 8'h01, 8'h05, 8'hAA, 8'hBB);
    check("mem05", mem[8'h05], 8'hAA);
    check("mem06", mem[8'h06], 8'hBB);

    // read from 0x10: status, status (no read yet), 0x3C, 0x5A
    base = got_miso.size();
    run_frame(4, 1'b0, 8'h02, 8'h10, 8'h00, 8'h00);
    check("rd_miso0", got_miso[base], 8'hA5);
    check("rd_miso2", got_miso[base + 2], 8'h3C);
    check("rd_miso3", got_miso[base + 3], 8'h5A);

    // address wrap
    run_frame(4, 1'b0, 8'h01, 8'hFF, 8'h11, 8'h22);
    check("memFF", mem[8'hFF], 8'h11);
    check("mem00", mem[8'h00], 8'h22);

    // start pulses
    run_frame(2, 1'b0, 8'h10, 8'h00);
    check("start_count1", n_start_seen, 1);
    run_frame(1, 1'b0, 8'h10);
    check("start_count2", n_start_seen, 2);

    // abort after address: no write; frame ending before address sets err
    w0 = n_wr_seen;
    run_frame(2, 1'b0, 8'h01, 8'h05);
    check("abort_no_wr", n_wr_seen - w0, 0);
    run_frame(1, 1'b0, 8'h01);
    run_frame(3, 1'b0, 8'h02, 8'h20, 8'h00);
    run_frame(1, 1'b0, 8'h20);

    // unknown opcode, then clear opcode
    run_frame(3, 1'b0, 8'h55, 8'h01, 8'h02);
    run_frame(1, 1'b0, 8'h20);

    // ssel rises together with the last byte
    run_frame(3, 1'b1, 8'h01, 8'h30, 8'h44);
    check("mem30", mem[8'h30], 8'h44);
    run_frame(2, 1'b1, 8'h02, 8'h40);
    run_frame(1, 1'b1, 8'h10);
    check("start_count3", n_start_seen, 3);

    // new status value, short read
    status_in = 8'h3E;
    repeat (2) @(posedge clk);
    base = got_miso.size();
    run_frame(3, 1'b0, 8'h02, 8'h11, 8'h00);
    check("st_miso0", got_miso[base], 8'h3E);

    // reset while reading; rest of the frame is discarded
    status_in = 8'h77;
    repeat (2) @(posedge clk);
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    #3 rst = 1'b1;
    model_reset(1'b1);
    @(negedge clk);
    check("midrst_tx", tx_data, 8'h00);
    check("midrst_strobes", {reg_rd_en, reg_wr_en, start}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    w0 = n_wr_seen;
    send_byte(8'h01, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h99, 1'b0);
    frame_end();
    check("midrst_no_wr", n_wr_seen - w0, 0);
    base = got_miso.size();
    run_frame(3, 1'b0, 8'h02, 8'h11, 8'h00);
    check("post_rst_rd", got_miso[base + 2], 8'h5A);

    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("start_left", exp_start, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
